irq_controller: RTL

Memory-mapped interrupt controller that sits directly downstream of the timer and other peripherals. It collects their irq_out lines, latches pending requests per source, masks them and resolves priority. It drives a single interrupt line to the CPU and exposes claim/complete registers. Bus protocol is the same AS_L/WE_L/register-select scheme used by the peripherals.

---
 rtl/irq_bus_if.sv | 23 ++
 rtl/irq_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/irq_bus_if.sv
// Peripheral register bus: AS_L/WE_L strobes, one-hot register selects, 32-bit data.
interface irq_bus_if;
  logic        AS_L;
  logic        WE_L;
  logic        pending_reg_select;
  logic        enable_reg_select;
  logic        mode_reg_select;
  logic        claim_reg_select;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output AS_L, WE_L, pending_reg_select, enable_reg_select,
           mode_reg_select, claim_reg_select, data_in,
    input  data_out
  );

  modport slave (
    input  AS_L, WE_L, pending_reg_select, enable_reg_select,
           mode_reg_select, claim_reg_select, data_in,
    output data_out
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: per-source pending latch (level/edge), enable mask,
// lowest-ID-first claim with in-service tracking, and a registered CPU request.
module irq_controller #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_bus_if.slave           bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq
);

  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 5;

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] in_service;
  logic               as_l_q;
  logic [DW-1:0]      data_out_q;

  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] enable_d;
  logic [NUM_SRC-1:0] mode_d;
  logic [NUM_SRC-1:0] in_service_d;
  logic [DW-1:0]      data_out_d;
  logic               cpu_irq_d;

  logic               start_c;
  logic               sel_claim_c;
  logic               sel_pend_c;
  logic               sel_en_c;
  logic               sel_mode_c;
  logic [NUM_SRC-1:0] hw_set_c;
  logic [IDW-1:0]     claim_id_c;
  logic [NUM_SRC-1:0] claim_mask_c;
  logic [NUM_SRC-1:0] complete_mask_c;
  logic               unused_data_in;

  assign unused_data_in = ^bus.data_in;

  // One access per falling strobe; select priority claim > pending > enable > mode.
  assign start_c     = !bus.AS_L && as_l_q;
  assign sel_claim_c = bus.claim_reg_select;
  assign sel_pend_c  = bus.pending_reg_select && !sel_claim_c;
  assign sel_en_c    = bus.enable_reg_select && !sel_claim_c && !bus.pending_reg_select;
  assign sel_mode_c  = bus.mode_reg_select && !sel_claim_c && !bus.pending_reg_select
                       && !bus.enable_reg_select;

  // Level sources are blocked while in service; edge sources latch any rising edge.
  assign hw_set_c = (~mode & irq_q & ~in_service) | (mode & irq_src & ~irq_q);

  // Lowest enabled pending source wins the claim; also decode the complete ID.
  always_comb begin
    logic found;
    found           = 1'b0;
    claim_id_c      = '0;
    claim_mask_c    = '0;
    complete_mask_c = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!found && pending[i] && enable[i]) begin
        found           = 1'b1;
        claim_id_c      = IDW'(i + 1);
        claim_mask_c[i] = 1'b1;
      end
      if (bus.data_in[IDW-1:0] == IDW'(i + 1)) begin
        complete_mask_c[i] = 1'b1;
      end
    end
  end

  // Register side effects and read data for the start cycle.
  always_comb begin
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] complete_clr;
    enable_d     = enable;
    mode_d       = mode;
    data_out_d   = data_out_q;
    w1c          = '0;
    claim_clr    = '0;
    complete_clr = '0;

    if (start_c) begin
      if (!bus.WE_L) begin
        if (sel_claim_c) begin
          complete_clr = complete_mask_c & in_service;
        end else if (sel_pend_c) begin
          w1c = bus.data_in[NUM_SRC-1:0];
        end else if (sel_en_c) begin
          enable_d = bus.data_in[NUM_SRC-1:0];
        end else if (sel_mode_c) begin
          mode_d = bus.data_in[NUM_SRC-1:0];
        end
      end else begin
        if (sel_claim_c) begin
          data_out_d = DW'(claim_id_c);
          claim_clr  = claim_mask_c;
        end else if (sel_pend_c) begin
          data_out_d = DW'(pending);
        end else if (sel_en_c) begin
          data_out_d = DW'(enable);
        end else if (sel_mode_c) begin
          data_out_d = DW'(mode);
        end else begin
          data_out_d = '0;
        end
      end
    end

    // Hardware set beats W1C; a claim beats a hardware set.
    pending_d    = ((pending & ~w1c) | hw_set_c) & ~claim_clr;
    in_service_d = (in_service & ~complete_clr) | claim_clr;
    cpu_irq_d    = |(pending & enable);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q      <= '0;
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      in_service <= '0;
      as_l_q     <= 1'b1;
      data_out_q <= '0;
      cpu_irq    <= 1'b0;
    end else begin
      irq_q      <= irq_src;
      pending    <= pending_d;
      enable     <= enable_d;
      mode       <= mode_d;
      in_service <= in_service_d;
      as_l_q     <= bus.AS_L;
      data_out_q <= data_out_d;
      cpu_irq    <= cpu_irq_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule
